// File: rtl/mul_acc_pkg.sv
// Shared FSM state encoding and default widths for the multiply-accumulate back end.
package mul_acc_pkg;

    localparam int unsigned DEFAULT_N       = 32;
    localparam int unsigned DEFAULT_COUNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mul_acc_datapath.sv
// Accumulator register with carry detection and sticky overflow.
// Defining MUL_ACC_SATURATE_EN clamps the sum to all ones on carry instead of wrapping.
module mul_acc_datapath #(
    parameter int unsigned N = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           accept,
    input  logic [2*N-1:0] product,
    input  logic           product_overflow,
    output logic [2*N-1:0] sum,
    output logic           overflow
);

    localparam int unsigned W = 2 * N;

    logic [W:0]   wide;
    logic         carry;
    logic [W-1:0] sum_next;

    assign wide  = {1'b0, sum} + {1'b0, product};
    assign carry = wide[W];

`ifdef MUL_ACC_SATURATE_EN
    // Once saturated, any nonzero product carries again, so the sum stays at all ones.
    assign sum_next = carry ? {W{1'b1}} : wide[W-1:0];
`else
    assign sum_next = wide[W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sum      <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            sum      <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            sum      <= sum_next;
            overflow <= overflow | product_overflow | carry;
        end
    end

endmodule

// File: rtl/mul_accumulator.sv
// Accumulates a programmed number of multiplier products and presents the sum with a valid/ready handshake.
// Optional MUL_ACC_SATURATE_EN (in mul_acc_datapath) selects saturating instead of wrapping accumulation.
module mul_accumulator
    import mul_acc_pkg::*;
#(
    parameter int unsigned N       = DEFAULT_N,
    parameter int unsigned COUNT_W = DEFAULT_COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    input  logic               in_valid,
    input  logic [2*N-1:0]     in_product,
    input  logic               in_overflow,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*N-1:0]     out_sum,
    output logic               out_overflow,
    output logic [COUNT_W-1:0] out_count,
    output logic               busy
);

    state_t             state;
    state_t             state_next;
    logic               clear;
    logic               accept;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] remaining;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (remaining == COUNT_W'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            remaining <= '0;
        end else if (clear) begin
            count     <= '0;
            remaining <= len;
        end else if (accept) begin
            count     <= count + COUNT_W'(1);
            remaining <= remaining - COUNT_W'(1);
        end
    end

    mul_acc_datapath #(
        .N(N)
    ) u_datapath (
        .clk              (clk),
        .reset            (reset),
        .clear            (clear),
        .accept           (accept),
        .product          (in_product),
        .product_overflow (in_overflow),
        .sum              (out_sum),
        .overflow         (out_overflow)
    );

    // Handshake and status flags decode straight from the state register.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_count = count;

endmodule

// File: tb/tb_mul_accumulator.sv
// Randomized self-checking bench for mul_accumulator against a whole-transaction arithmetic model.
module tb_mul_accumulator;

    localparam int unsigned N       = 32;
    localparam int unsigned COUNT_W = 8;
    localparam int unsigned W       = 2 * N;
    localparam logic [W-1:0] MAXV   = {W{1'b1}};

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [COUNT_W-1:0] len;
    logic               in_valid;
    logic [W-1:0]       in_product;
    logic               in_overflow;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_sum;
    logic               out_overflow;
    logic [COUNT_W-1:0] out_count;
    logic               busy;

    int vectors = 0;
    int errors  = 0;

    logic [W-1:0] prod_q[$];
    bit           ovf_q[$];

    mul_accumulator #(.N(N), .COUNT_W(COUNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .len          (len),
        .in_valid     (in_valid),
        .in_product   (in_product),
        .in_overflow  (in_overflow),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_overflow (out_overflow),
        .out_count    (out_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one transaction from prod_q/ovf_q; the expected result is the plain arithmetic total.
    task automatic do_txn(input int gap_max, input int hold);
        logic [79:0]        total;
        bit                 any_ovf;
        logic [W-1:0]       e_sum;
        logic               e_ovf;
        int                 n;
        n       = prod_q.size();
        total   = '0;
        any_ovf = 1'b0;
        foreach (prod_q[i]) begin
            total   = total + 80'(prod_q[i]);
            any_ovf = any_ovf | ovf_q[i];
        end
        e_ovf = any_ovf || (total > 80'(MAXV));
`ifdef MUL_ACC_SATURATE_EN
        e_sum = (total > 80'(MAXV)) ? MAXV : total[W-1:0];
`else
        e_sum = total[W-1:0];
`endif
        start = 1'b1;
        len   = COUNT_W'(n);
        step();
        start = 1'b0;
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b exp 1", busy); end
        vectors++; if (out_sum !== '0) begin errors++; $display("FAIL sum_cleared: got %h exp 0", out_sum); end
        vectors++; if (out_count !== '0) begin errors++; $display("FAIL count_cleared: got %0d exp 0", out_count); end
        if (n == 0) begin
            vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL zero_len_ready: got %b exp 0", in_ready); end
        end
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                in_product = {$urandom, $urandom};
                vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL gap_ready: got %b exp 1", in_ready); end
                step();
            end
            vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_ready: got %b exp 1", in_ready); end
            in_valid    = 1'b1;
            in_product  = prod_q[i];
            in_overflow = ovf_q[i];
            step();
            in_valid    = 1'b0;
            in_overflow = 1'b0;
        end
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL done_valid: got %b exp 1", out_valid); end
        vectors++; if (out_sum !== e_sum) begin errors++; $display("FAIL done_sum: got %h exp %h", out_sum, e_sum); end
        vectors++; if (out_overflow !== e_ovf) begin errors++; $display("FAIL done_ovf: got %b exp %b", out_overflow, e_ovf); end
        vectors++; if (out_count !== COUNT_W'(n)) begin errors++; $display("FAIL done_count: got %0d exp %0d", out_count, n); end
        for (int h = 0; h < hold; h++) begin
            start       = 1'b1;
            len         = COUNT_W'($urandom_range(1, 9));
            in_valid    = 1'b1;
            in_product  = {$urandom, $urandom};
            in_overflow = 1'b1;
            step();
            vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b exp 1", out_valid); end
            vectors++; if (out_sum !== e_sum) begin errors++; $display("FAIL hold_sum: got %h exp %h", out_sum, e_sum); end
            vectors++; if (out_overflow !== e_ovf || out_count !== COUNT_W'(n)) begin errors++; $display("FAIL hold_status: got ovf %b cnt %0d exp ovf %b cnt %0d", out_overflow, out_count, e_ovf, n); end
        end
        start       = 1'b0;
        in_valid    = 1'b0;
        in_overflow = 1'b0;
        out_ready   = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL to_idle: got valid %b busy %b exp 0 0", out_valid, busy); end
        in_valid    = 1'b1;
        in_product  = {$urandom, $urandom};
        in_overflow = 1'b1;
        step();
        in_valid    = 1'b0;
        in_overflow = 1'b0;
        vectors++; if (out_sum !== e_sum || out_count !== COUNT_W'(n) || out_overflow !== e_ovf) begin errors++; $display("FAIL idle_keep: got sum %h cnt %0d ovf %b exp %h %0d %b", out_sum, out_count, out_overflow, e_sum, n, e_ovf); end
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b exp 0", in_ready); end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        in_product = '0; in_overflow = 1'b0; out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        vectors++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy %b rdy %b vld %b exp 0 0 0", busy, in_ready, out_valid); end
        vectors++; if (out_sum !== '0 || out_overflow !== 1'b0 || out_count !== '0) begin errors++; $display("FAIL reset_data: got sum %h ovf %b cnt %0d exp 0", out_sum, out_overflow, out_count); end
    endtask

    task automatic test_basic();
        prod_q = '{64'd5, 64'd7, 64'd9};
        ovf_q  = '{1'b0, 1'b0, 1'b0};
        do_txn(0, 0);
        vectors++; if (out_sum !== 64'd21 || out_count !== 8'd3 || out_overflow !== 1'b0) begin errors++; $display("FAIL basic_const: got sum %0d cnt %0d ovf %b exp 21 3 0", out_sum, out_count, out_overflow); end
    endtask

    task automatic test_zero_len();
        prod_q = {};
        ovf_q  = {};
        do_txn(0, 0);
        vectors++; if (out_sum !== '0 || out_count !== '0) begin errors++; $display("FAIL zero_const: got sum %h cnt %0d exp 0 0", out_sum, out_count); end
    endtask

    task automatic test_wrap_saturate();
        logic [W-1:0] exp_sum;
        prod_q = '{MAXV, 64'd2};
        ovf_q  = '{1'b0, 1'b0};
        do_txn(1, 0);
`ifdef MUL_ACC_SATURATE_EN
        exp_sum = MAXV;
`else
        exp_sum = 64'd1;
`endif
        vectors++; if (out_sum !== exp_sum || out_overflow !== 1'b1) begin errors++; $display("FAIL wrap_const: got sum %h ovf %b exp %h 1", out_sum, out_overflow, exp_sum); end
    endtask

    task automatic test_back_pressure();
        prod_q = '{64'd100, 64'd200};
        ovf_q  = '{1'b0, 1'b0};
        do_txn(2, 5);
    endtask

    task automatic test_in_overflow();
        prod_q = '{64'd11, 64'd22, 64'd33, 64'd44};
        ovf_q  = '{1'b0, 1'b1, 1'b0, 1'b0};
        do_txn(0, 1);
        vectors++; if (out_sum !== 64'd110 || out_overflow !== 1'b1) begin errors++; $display("FAIL inovf_const: got sum %0d ovf %b exp 110 1", out_sum, out_overflow); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        len   = 8'd4;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid   = 1'b1;
            in_product = 64'(i + 3);
            step();
        end
        reset       = 1'b1;
        in_product  = 64'd50;
        in_overflow = 1'b1;
        step();
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_overflow = 1'b0;
        vectors++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL midreset_flags: got busy %b rdy %b vld %b exp 0 0 0", busy, in_ready, out_valid); end
        vectors++; if (out_sum !== '0 || out_overflow !== 1'b0 || out_count !== '0) begin errors++; $display("FAIL midreset_data: got sum %h ovf %b cnt %0d exp 0", out_sum, out_overflow, out_count); end
        prod_q = '{64'd4};
        ovf_q  = '{1'b0};
        do_txn(0, 0);
        vectors++; if (out_sum !== 64'd4) begin errors++; $display("FAIL midreset_restart: got %0d exp 4", out_sum); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int n;
            n      = $urandom_range(0, 6);
            prod_q = {};
            ovf_q  = {};
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0:       prod_q.push_back(64'($urandom_range(0, 1000)));
                    1:       prod_q.push_back(MAXV - 64'($urandom_range(0, 3)));
                    default: prod_q.push_back({$urandom, $urandom});
                endcase
                ovf_q.push_back($urandom_range(0, 7) == 0);
            end
            do_txn(3, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_wrap_saturate();
        test_back_pressure();
        test_in_overflow();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mul_accumulator.md
MUL_ACCUMULATOR -- requirements
Module: mul_accumulator

Interface
REQ-001 Parameter N, default 32: operand width of the upstream multiplier; product and sum width is 2N.
REQ-002 Parameter COUNT_W, default 8: width of the length and count fields.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  requests a new accumulation of len products; sampled only in IDLE.
REQ-006 len  input  COUNT_W  number of products to accumulate; sampled with start.
REQ-007 in_valid  input  1  in_product and in_overflow are valid this cycle.
REQ-008 in_product  input  2N  product from the registered tree multiplier.
REQ-009 in_overflow  input  1  overflow flag from the registered tree multiplier.
REQ-010 in_ready  output  1  block accepts a product this cycle.
REQ-011 out_valid  output  1  final sum is available.
REQ-012 out_ready  input  1  downstream consumes the sum.
REQ-013 out_sum  output  2N  accumulated sum.
REQ-014 out_overflow  output  1  sticky overflow for the current accumulation.
REQ-015 out_count  output  COUNT_W  number of products accepted so far.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-018 In IDLE, start=1 SHALL clear the accumulator, overflow and count, load remaining=len, and move to ACCUM, or to DONE if len=0.
REQ-019 start SHALL be ignored in ACCUM and DONE.
REQ-020 in_ready SHALL be 1 only in ACCUM; a product is accepted when in_valid and in_ready are both 1.
REQ-021 On accept, the accumulator SHALL become acc+in_product and the count SHALL increment.
REQ-022 On accept, out_overflow SHALL OR in both in_overflow and the carry out of the 2N-bit add.
REQ-023 If the last product (remaining=1) is accepted in cycle t, the FSM SHALL be in DONE with out_valid=1 in cycle t+1.
REQ-024 In DONE, out_sum, out_overflow and out_count SHALL hold stable until out_valid and out_ready are both 1; the FSM then returns to IDLE.
REQ-025 out_sum, out_overflow and out_count SHALL keep their last values in IDLE until the next start.
REQ-026 in_valid while not in ACCUM SHALL have no effect.
REQ-027 All outputs SHALL be driven from registers or decoded only from the FSM state.

Reset
REQ-028 reset=1 SHALL put the FSM in IDLE and clear out_sum, out_overflow and out_count to 0 at the next edge; out_valid and in_ready are 0 and busy is 0.
REQ-029 reset SHALL take priority over start, an accept and an out handshake in the same cycle.
REQ-030 Reset in ACCUM or DONE SHALL discard the partial result with no output handshake.

Configuration
REQ-031 With MUL_ACC_SATURATE_EN defined, a carry out SHALL force the accumulator to all ones, and it SHALL hold all ones for the rest of the accumulation.
REQ-032 Without MUL_ACC_SATURATE_EN, the accumulator SHALL wrap modulo 2^(2N).
REQ-033 The sticky overflow SHALL be set identically in both configurations.

Structure
REQ-034 Package mul_acc_pkg SHALL hold the FSM state enum (IDLE=0, ACCUM=1, DONE=2) and default width constants.
REQ-035 Sub-module mul_acc_datapath SHALL hold the adder, carry and saturation logic; the FSM stays in the top module.

Verification
REQ-036 Basic: start len=3, products 5, 7, 9 with no gaps -> out_valid one cycle after the third accept; out_sum=21, out_count=3, out_overflow=0.
REQ-037 Zero length: start len=0 -> DONE on the next cycle; out_sum=0, out_count=0, no in_ready pulse.
REQ-038 Wrap and saturate: products 2^64-1 then 2 (N=32) -> out_overflow=1; out_sum=1 without the macro, 2^64-1 with it.
REQ-039 Back-pressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_sum held stable; start pulses ignored; IDLE one cycle after out_ready=1.
REQ-040 Input overflow: in_overflow=1 on the second of 4 products -> out_overflow=1; the sum is unaffected.
REQ-041 Reset mid-ACCUM after 2 of 4 products -> IDLE with all outputs 0 at the next edge; a new start len=1 with product 4 -> out_sum=4.
